mbf_fir_cfg_rx: RTL and testbench
=================================

MBF_FIR_CFG_RX -- requirements
Module: mbf_fir_cfg_rx

Interface
REQ-001 The block SHALL have parameter FIR_CONFIG_DATA_WIDTH, default 24, the config word and coefficient width.
REQ-002 The block SHALL have parameter FILTER_MAX_ORDER, default 32, the filter order; the coefficient count is FILTER_MAX_ORDER+1.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port isConfigFIR_In, input, 1 bit: the one-cycle start-of-load strobe.
REQ-006 The block SHALL have port Data_ConfigFIR_In, input, signed FIR_CONFIG_DATA_WIDTH bits: the config word stream.
REQ-007 The block SHALL have port isFilterBusy, input, 1 bit: when high, commit to the active bank is held off.
REQ-008 The block SHALL have port Coef_Addr, input, 6 bits: the coefficient read address.
REQ-009 The block SHALL have port Coef_Out, output, signed FIR_CONFIG_DATA_WIDTH bits: the active coefficient at Coef_Addr.
REQ-010 The block SHALL have port isCoefSym_Out, output, 1 bit: the active symmetry flag.
REQ-011 The block SHALL have port isConfigACKFIR_Out, output, 1 bit: high while a load is in progress or a commit is pending.
REQ-012 The block SHALL have port isConfigDoneFIR_Out, output, 1 bit: a one-cycle pulse on commit.

Function
REQ-013 Word framing SHALL be: start strobe in cycle t; words 0..FILTER_MAX_ORDER are coefficients, sampled in cycles t+1..t+FILTER_MAX_ORDER+1; the next word, sampled in cycle t+FILTER_MAX_ORDER+2, is the isCoefSym word.
REQ-014 The state machine SHALL have the states IDLE, LOAD, PEND and COMMIT.
REQ-015 IDLE SHALL go to LOAD on isConfigFIR_In, clear the word counter and assert ACK at the next edge.
REQ-016 In LOAD, each cycle SHALL write Data_ConfigFIR_In into shadow[counter] and increment the counter.
REQ-017 On the sym word, LOAD SHALL latch shadow_sym = (word != 0) and go to PEND.
REQ-018 PEND SHALL stay in PEND while isFilterBusy=1, and go to COMMIT in the first cycle isFilterBusy=0.
REQ-019 COMMIT SHALL copy all shadow coefficients and shadow_sym into the active bank in one cycle.
REQ-020 COMMIT SHALL pulse isConfigDoneFIR_Out for exactly one cycle, deassert ACK in that same cycle, and go to IDLE.
REQ-021 With isFilterBusy=0, Done SHALL rise exactly FILTER_MAX_ORDER+4 cycles after the start strobe.
REQ-022 A start strobe in LOAD or PEND SHALL restart the load at word 0, discard the shadow contents, and leave the active bank untouched.
REQ-023 A start strobe in COMMIT SHALL let the commit complete and SHALL also begin a new LOAD at the next edge, with ACK remaining high.
REQ-024 The active bank SHALL change only in COMMIT; a partial load SHALL never be visible on Coef_Out.
REQ-025 Coef_Out SHALL be registered with 1-cycle latency from Coef_Addr.
REQ-026 An address greater than FILTER_MAX_ORDER SHALL return 0.
REQ-027 A read in the COMMIT cycle SHALL return the old value, and the new value from the next cycle on.
REQ-028 Data SHALL be stored at full width with no truncation or sign alteration.
REQ-029 An illegal state encoding SHALL go to IDLE.

Reset
REQ-030 While RST=1, the state SHALL be IDLE and the counter 0.
REQ-031 While RST=1, the active and shadow coefficients SHALL be 0 and both sym flags 0.
REQ-032 While RST=1, Coef_Out=0, isCoefSym_Out=0, ACK=0 and Done=0.
REQ-033 Reset asserted mid-load SHALL abandon the load with no Done pulse.

Structure
REQ-034 A shared package mbf_pkg SHALL hold the state encodings, FIR_CONFIG_DATA_WIDTH, FILTER_MAX_ORDER and the address width.
REQ-035 The block SHALL have one sub-module, mbf_coef_bank: the shadow/active register pair with the commit strobe and the registered read port.
REQ-036 The state machine and counter SHALL live in the top level.

Verification
REQ-037 Nominal load: strobe, then coefficients k*3-50 for k=0..32, then sym word 1, with isFilterBusy=0 -> Done at strobe+36; Coef_Addr=5 reads -35; isCoefSym_Out=1.
REQ-038 Busy hold: isFilterBusy=1 for 10 cycles after the sym word -> ACK stays 1, the old coefficients remain readable, and Done comes 1 cycle after busy drops.
REQ-039 Abort and restart: second strobe at word 17 of the first load -> only the second load's 33 coefficients are committed, with exactly one Done.
REQ-040 Reset mid-load: RST at word 10 -> all reads return 0 and no Done pulse occurs.
REQ-041 Boundaries: Coef_Addr=33 or 63 -> Coef_Out=0; sym word 0x800000 -> sym=1; coefficient 0x7FFFFF and 0x800000 -> read back exactly.
REQ-042 Commit overlap: strobe in the COMMIT cycle -> Done pulses, ACK stays 1, and the second load completes correctly.

Source files
------------

// File: rtl/mbf_pkg.sv
// Shared definitions for the FIR configuration receiver: default sizes,
// the read address width and the load/commit state encoding.
package mbf_pkg;
    localparam int FIR_CONFIG_DATA_WIDTH = 24;
    localparam int FILTER_MAX_ORDER      = 32;
    localparam int ADDR_W                = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PEND   = 2'd2,
        ST_COMMIT = 2'd3
    } fsm_state_e;
endpackage

// File: rtl/mbf_fir_cfg_rx_if.sv
// Config stream, busy handshake and coefficient read port of the FIR config
// receiver; master drives the stream and reads, slave is the receiver.
interface mbf_fir_cfg_rx_if
    import mbf_pkg::*;
#(
    parameter int DW = FIR_CONFIG_DATA_WIDTH,
    parameter int AW = ADDR_W
);
    logic                 isConfigFIR_In;
    logic signed [DW-1:0] Data_ConfigFIR_In;
    logic                 isFilterBusy;
    logic [AW-1:0]        Coef_Addr;
    logic signed [DW-1:0] Coef_Out;
    logic                 isCoefSym_Out;
    logic                 isConfigACKFIR_Out;
    logic                 isConfigDoneFIR_Out;

    modport master (
        output isConfigFIR_In, Data_ConfigFIR_In, isFilterBusy, Coef_Addr,
        input  Coef_Out, isCoefSym_Out, isConfigACKFIR_Out, isConfigDoneFIR_Out
    );

    modport slave (
        input  isConfigFIR_In, Data_ConfigFIR_In, isFilterBusy, Coef_Addr,
        output Coef_Out, isCoefSym_Out, isConfigACKFIR_Out, isConfigDoneFIR_Out
    );
endinterface

// File: rtl/mbf_coef_bank.sv
// Shadow/active coefficient register pair: loads land in the shadow bank and
// reach the active bank only on a commit strobe; reads are registered.
module mbf_coef_bank
    import mbf_pkg::*;
#(
    parameter int DW    = FIR_CONFIG_DATA_WIDTH,
    parameter int ORDER = FILTER_MAX_ORDER,
    parameter int AW    = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 sym_wr_en,
    input  logic                 sym_data,
    input  logic                 commit,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [DW-1:0] rd_data,
    output logic                 sym_out
);
    logic signed [DW-1:0] shadow_q [ORDER+1];
    logic signed [DW-1:0] shadow_d [ORDER+1];
    logic signed [DW-1:0] active_q [ORDER+1];
    logic signed [DW-1:0] active_d [ORDER+1];
    logic                 shadow_sym_q, shadow_sym_d;
    logic                 active_sym_q, active_sym_d;
    logic signed [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i <= ORDER; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
        shadow_sym_d = sym_wr_en ? sym_data : shadow_sym_q;
    end

    always_comb begin
        if (commit) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
        active_sym_d = commit ? shadow_sym_q : active_sym_q;
    end

    // Addresses past the last tap match no entry and therefore read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i <= ORDER; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data_d = active_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ORDER; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            shadow_sym_q <= 1'b0;
            active_sym_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            shadow_sym_q <= shadow_sym_d;
            active_sym_q <= active_sym_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign sym_out = active_sym_q;
endmodule

// File: rtl/mbf_fir_cfg_rx.sv
// FIR configuration receiver: frames a strobed stream of coefficients plus a
// symmetry word into a shadow bank and commits it once the filter is idle.
module mbf_fir_cfg_rx #(
    parameter int FIR_CONFIG_DATA_WIDTH = mbf_pkg::FIR_CONFIG_DATA_WIDTH,
    parameter int FILTER_MAX_ORDER      = mbf_pkg::FILTER_MAX_ORDER
) (
    input logic             CLK,
    input logic             RST,
    mbf_fir_cfg_rx_if.slave bus
);
    import mbf_pkg::*;

    localparam int            AW      = ADDR_W;
    localparam logic [AW-1:0] SYM_IDX = AW'(FILTER_MAX_ORDER + 1);

    fsm_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en, sym_wr_en, commit, ack, done;
    logic          strobe;

    assign strobe = bus.isConfigFIR_In;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A strobe in any state restarts framing at word 0; COMMIT still finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (strobe) begin
                    cnt_d = '0;
                end else if (cnt_q == SYM_IDX) begin
                    state_d = ST_PEND;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_PEND: begin
                if (strobe) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (!bus.isFilterBusy) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = strobe ? ST_LOAD : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en     = (state_q == ST_LOAD) && !strobe && (cnt_q != SYM_IDX);
        sym_wr_en = (state_q == ST_LOAD) && !strobe && (cnt_q == SYM_IDX);
        commit    = (state_q == ST_COMMIT);
        done      = commit;
        ack       = (state_q == ST_LOAD) || (state_q == ST_PEND) || (commit && strobe);
    end

    mbf_coef_bank #(
        .DW    (FIR_CONFIG_DATA_WIDTH),
        .ORDER (FILTER_MAX_ORDER),
        .AW    (AW)
    ) u_bank (
        .clk       (CLK),
        .rst       (RST),
        .wr_en     (wr_en),
        .wr_addr   (cnt_q),
        .wr_data   (bus.Data_ConfigFIR_In),
        .sym_wr_en (sym_wr_en),
        .sym_data  (bus.Data_ConfigFIR_In != '0),
        .commit    (commit),
        .rd_addr   (bus.Coef_Addr),
        .rd_data   (bus.Coef_Out),
        .sym_out   (bus.isCoefSym_Out)
    );

    assign bus.isConfigACKFIR_Out  = ack;
    assign bus.isConfigDoneFIR_Out = done;
endmodule

// File: tb/tb_mbf_fir_cfg_rx.sv
// Scoreboard bench for mbf_fir_cfg_rx: stimulus pushes expected outputs per
// cycle from a bank-level model, a negedge monitor pops and compares them.
module tb_mbf_fir_cfg_rx;
    import mbf_pkg::*;

    localparam int W      = FIR_CONFIG_DATA_WIDTH;
    localparam int N      = FILTER_MAX_ORDER;
    localparam int K_COEF = 0;
    localparam int K_SYM  = 1;
    localparam int K_ACK  = 2;
    localparam int K_DONE = 3;

    typedef struct packed {
        int         due;
        logic [1:0] kind;
        logic [W-1:0] val;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t                exp_q [$];
    logic signed [W-1:0] act_m [N+1];
    logic signed [W-1:0] new_c [N+1];
    bit                  sym_m = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mbf_fir_cfg_rx_if #(.DW(W), .AW(ADDR_W)) bus ();

    mbf_fir_cfg_rx #(
        .FIR_CONFIG_DATA_WIDTH (W),
        .FILTER_MAX_ORDER      (N)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [W-1:0] rndWord();
        return W'($urandom());
    endfunction

    function automatic logic [W-1:0] modelRead(input int a);
        if (a <= N) return act_m[a];
        return '0;
    endfunction

    function automatic void pushExp(input int due, input int kind, input logic [W-1:0] val);
        exp_t e;
        e.due  = due;
        e.kind = 2'(kind);
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [W-1:0] got;
        string        nm;
        case (e.kind)
            2'd0:    begin got = bus.Coef_Out;                                 nm = "coef"; end
            2'd1:    begin got = {{(W-1){1'b0}}, bus.isCoefSym_Out};           nm = "sym";  end
            2'd2:    begin got = {{(W-1){1'b0}}, bus.isConfigACKFIR_Out};      nm = "ack";  end
            default: begin got = {{(W-1){1'b0}}, bus.isConfigDoneFIR_Out};     nm = "done"; end
        endcase
        n_vec++;
        if (got !== e.val) begin
            n_err++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, e.val);
        end
    endtask

    always @(negedge CLK) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                checkOutput(exp_q[i]);
                exp_q.delete(i);
            end else if (exp_q[i].due < cyc) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL stale_expectation due=%0d cyc=%0d", exp_q[i].due, cyc);
                exp_q.delete(i);
            end
        end
    end

    // One clock cycle of stimulus plus the outputs the model predicts for it.
    task automatic applyStimulus(input bit strobe, input logic [W-1:0] data, input bit busy,
                                 input bit exp_ack, input bit exp_done, input bit do_read,
                                 input int addr);
        @(posedge CLK);
        #1;
        RST                   = 1'b0;
        bus.isConfigFIR_In    = strobe;
        bus.Data_ConfigFIR_In = data;
        bus.isFilterBusy      = busy;
        bus.Coef_Addr         = ADDR_W'(addr);
        pushExp(cyc, K_ACK,  W'(exp_ack));
        pushExp(cyc, K_DONE, W'(exp_done));
        pushExp(cyc, K_SYM,  W'(sym_m));
        if (do_read) pushExp(cyc + 1, K_COEF, modelRead(addr));
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            RST                   = 1'b1;
            bus.isConfigFIR_In    = 1'b0;
            bus.Data_ConfigFIR_In = '0;
            bus.isFilterBusy      = 1'b0;
            bus.Coef_Addr         = '0;
            pushExp(cyc, K_ACK,  '0);
            pushExp(cyc, K_DONE, '0);
            pushExp(cyc, K_SYM,  '0);
            pushExp(cyc, K_COEF, '0);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, rndWord(), 1'($urandom()), 1'b0, 1'b0, 1'b1,
                          int'($urandom_range(0, 63)));
        end
    endtask

    task automatic readAt(input int addr);
        applyStimulus(1'b0, rndWord(), 1'($urandom()), 1'b0, 1'b0, 1'b1, addr);
    endtask

    // Strobe plus n coefficient words of a load that will never complete.
    task automatic partialLoad(input int n, input bit rd);
        for (int k = 0; k <= n; k++) begin
            applyStimulus(k == 0, rndWord(), 1'($urandom()), k >= 1, 1'b0, rd,
                          int'($urandom_range(0, 63)));
        end
    endtask

    // Full load of new_c: offset k counts cycles from the strobe; the commit
    // lands at N+4+busy_len, and the model bank changes only after that cycle.
    task automatic doLoad(input bit started, input logic [W-1:0] symw, input int busy_len,
                          input bit overlap);
        int           kc;
        bit           s, b, a;
        logic [W-1:0] d;
        kc = N + 4 + busy_len;
        for (int k = (started ? 1 : 0); k <= kc; k++) begin
            s = (k == 0) || (k == kc && overlap);
            if (k >= 1 && k <= N + 1)            d = new_c[k-1];
            else if (k == N + 2)                 d = symw;
            else                                 d = rndWord();
            if (k >= N + 3 && k < N + 3 + busy_len) b = 1'b1;
            else if (k == N + 3 + busy_len)         b = 1'b0;
            else                                    b = 1'($urandom());
            a = (k >= 1 && k < kc) || (k == kc && overlap);
            applyStimulus(s, d, b, a, k == kc, 1'b1, int'($urandom_range(0, 63)));
        end
        act_m = new_c;
        sym_m = (symw != '0);
    endtask

    task automatic randomCoefs();
        for (int i = 0; i <= N; i++) new_c[i] = rndWord();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i <= N; i++) act_m[i] = '0;
        bus.isConfigFIR_In    = 1'b0;
        bus.Data_ConfigFIR_In = '0;
        bus.isFilterBusy      = 1'b0;
        bus.Coef_Addr         = '0;
        resetCycles(3);
        idleCycles(4);

        $display("[TB] nominal load");
        for (int k = 0; k <= N; k++) new_c[k] = W'(k * 3 - 50);
        doLoad(1'b0, W'(1), 0, 1'b0);
        readAt(5);
        idleCycles(6);

        $display("[TB] busy hold");
        randomCoefs();
        doLoad(1'b0, rndWord(), 10, 1'b0);
        idleCycles(6);

        $display("[TB] abort and restart");
        partialLoad(17, 1'b1);
        applyStimulus(1'b1, rndWord(), 1'($urandom()), 1'b1, 1'b0, 1'b1, int'($urandom_range(0, 63)));
        randomCoefs();
        doLoad(1'b1, rndWord(), int'($urandom_range(0, 3)), 1'b0);
        idleCycles(6);

        $display("[TB] commit overlap");
        randomCoefs();
        doLoad(1'b0, rndWord(), 2, 1'b1);
        randomCoefs();
        doLoad(1'b1, W'(24'h000001), 0, 1'b0);
        idleCycles(4);

        $display("[TB] boundaries");
        randomCoefs();
        new_c[0]  = W'(24'h7FFFFF);
        new_c[7]  = W'(24'h800000);
        new_c[N]  = W'(24'h800000);
        doLoad(1'b0, W'(24'h800000), 1, 1'b0);
        readAt(0);
        readAt(7);
        readAt(N);
        readAt(N + 1);
        readAt(63);
        idleCycles(4);

        $display("[TB] reset mid-load");
        partialLoad(10, 1'b0);
        resetCycles(3);
        for (int i = 0; i <= N; i++) act_m[i] = '0;
        sym_m = 1'b0;
        idleCycles(40);

        repeat (3) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL leftover_expectations got=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
